// File: rtl/midi_tx.sv
// Serial MIDI Note On transmitter: status/note/velocity frames with optional
// running status and selectable wire bit order.
module midi_tx #(
  parameter int unsigned INPUT_CLOCK_FREQ = 100_000_000,
  parameter int unsigned BAUD_RATE        = 31_250,
  parameter int unsigned MSB_FIRST        = 1,
  parameter int unsigned RUNNING_STATUS   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       msg_valid,
  output logic       msg_ready,
  input  logic       msg_on,
  input  logic [3:0] msg_channel,
  input  logic [6:0] msg_note,
  input  logic [6:0] msg_velocity,
  output logic       data_out,
  output logic       busy
);

  localparam int unsigned BIT_P = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CW    = (BIT_P > 1) ? $clog2(BIT_P) : 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(BIT_P - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  typedef enum logic [1:0] {SEL_STATUS, SEL_NOTE, SEL_VEL} sel_t;

  state_t        state;
  sel_t          cur;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [7:0]    note_b;
  logic [7:0]    vel_b;
  logic [7:0]    last_status;

  logic [7:0] status_b;
  logic       skip_status;
  logic       accept;
  logic       clk_done;
  logic       out_bit;
  logic [7:0] shifted;

  always_comb begin
    status_b    = {4'h9, msg_channel};
    skip_status = (RUNNING_STATUS != 0) && (status_b == last_status);
    accept      = msg_valid && msg_ready;
    clk_done    = (clk_cnt == CLK_LAST);
    out_bit     = (MSB_FIRST != 0) ? shreg[7] : shreg[0];
    shifted     = (MSB_FIRST != 0) ? {shreg[6:0], 1'b0} : {1'b0, shreg[7:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cur         <= SEL_STATUS;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      note_b      <= '0;
      vel_b       <= '0;
      last_status <= '0;
      data_out    <= 1'b1;
      msg_ready   <= 1'b1;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            note_b    <= {1'b0, msg_note};
            vel_b     <= msg_on ? {1'b0, msg_velocity} : '0;
            msg_ready <= 1'b0;
            busy      <= 1'b1;
            data_out  <= 1'b0;
            clk_cnt   <= '0;
            state     <= START;
            if (skip_status) begin
              shreg <= {1'b0, msg_note};
              cur   <= SEL_NOTE;
            end else begin
              shreg       <= status_b;
              cur         <= SEL_STATUS;
              last_status <= status_b;
            end
          end
        end
        START: begin
          if (clk_done) begin
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            data_out <= out_bit;
            shreg    <= shifted;
            state    <= DATA;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        DATA: begin
          if (clk_done) begin
            clk_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              data_out <= 1'b1;
              state    <= STOP;
            end else begin
              bit_cnt  <= bit_cnt + 3'd1;
              data_out <= out_bit;
              shreg    <= shifted;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        STOP: begin
          if (clk_done) begin
            clk_cnt <= '0;
            case (cur)
              SEL_STATUS: begin
                shreg    <= note_b;
                cur      <= SEL_NOTE;
                data_out <= 1'b0;
                state    <= START;
              end
              SEL_NOTE: begin
                shreg    <= vel_b;
                cur      <= SEL_VEL;
                data_out <= 1'b0;
                state    <= START;
              end
              default: begin
                msg_ready <= 1'b1;
                busy      <= 1'b0;
                state     <= IDLE;
              end
            endcase
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_midi_tx.sv
// Directed bench for midi_tx: two instances (MSB-first with running status,
// LSB-first without), 8-cycle bit period, frames decoded at mid-bit.
module tb_midi_tx;

  localparam int unsigned BP = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       a_valid, a_ready, a_on, a_data, a_busy;
  logic [3:0] a_ch;
  logic [6:0] a_note, a_vel;
  logic       b_valid, b_ready, b_on, b_data, b_busy;
  logic [3:0] b_ch;
  logic [6:0] b_note, b_vel;

  midi_tx #(.INPUT_CLOCK_FREQ(80), .BAUD_RATE(10), .MSB_FIRST(1), .RUNNING_STATUS(1)) u_a (
    .clk(clk), .rst(rst), .msg_valid(a_valid), .msg_ready(a_ready), .msg_on(a_on),
    .msg_channel(a_ch), .msg_note(a_note), .msg_velocity(a_vel),
    .data_out(a_data), .busy(a_busy));

  midi_tx #(.INPUT_CLOCK_FREQ(80), .BAUD_RATE(10), .MSB_FIRST(0), .RUNNING_STATUS(0)) u_b (
    .clk(clk), .rst(rst), .msg_valid(b_valid), .msg_ready(b_ready), .msg_on(b_on),
    .msg_channel(b_ch), .msg_note(b_note), .msg_velocity(b_vel),
    .data_out(b_data), .busy(b_busy));

  typedef struct {
    logic       on;
    logic [3:0] ch;
    logic [6:0] note;
    logic [6:0] vel;
    bit         hold;
    int         nb;
    logic [7:0] b [3];
  } vec_t;

  int npass = 0;
  int ntot  = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input bit sel, input logic v, input logic on, input logic [3:0] ch,
                       input logic [6:0] note, input logic [6:0] vel);
    if (sel) begin
      b_valid = v; b_on = on; b_ch = ch; b_note = note; b_vel = vel;
    end else begin
      a_valid = v; a_on = on; a_ch = ch; a_note = note; a_vel = vel;
    end
  endtask

  function automatic logic dout(input bit sel);
    return sel ? b_data : a_data;
  endfunction
  function automatic logic rdy(input bit sel);
    return sel ? b_ready : a_ready;
  endfunction
  function automatic logic bsy(input bit sel);
    return sel ? b_busy : a_busy;
  endfunction

  // Sends one event and decodes every frame; nx supplies the input values
  // presented while busy (held valid when v.hold is set).
  task automatic run_vec(input bit sel, input vec_t v, input vec_t nx, input string tag);
    int t;
    logic [9:0] bits;
    logic [7:0] byt;
    t = 0;
    while (!rdy(sel) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check({tag, " ready_wait"}, {7'd0, rdy(sel)}, 8'h01);
    @(negedge clk);
    check({tag, " idle_line"}, {7'd0, dout(sel)}, 8'h01);
    drive(sel, 1'b1, v.on, v.ch, v.note, v.vel);
    @(posedge clk);
    #1;
    if (v.hold) drive(sel, 1'b1, nx.on, nx.ch, nx.note, nx.vel);
    else drive(sel, 1'b0, ~v.on, ~v.ch, ~v.note, ~v.vel);
    check({tag, " start_edge"}, {7'd0, dout(sel)}, 8'h00);
    check({tag, " ready_low"}, {6'd0, rdy(sel), bsy(sel)}, 8'h01);
    repeat (BP / 2) @(posedge clk);
    #1;
    for (int f = 0; f < v.nb; f++) begin
      for (int k = 0; k < 10; k++) begin
        if (f != 0 || k != 0) begin
          repeat (BP) @(posedge clk);
          #1;
        end
        bits[k] = dout(sel);
      end
      for (int k = 0; k < 8; k++) byt[sel ? k : 7 - k] = bits[k + 1];
      check($sformatf("%s f%0d start", tag, f), {7'd0, bits[0]}, 8'h00);
      check($sformatf("%s f%0d byte", tag, f), byt, v.b[f]);
      check($sformatf("%s f%0d stop", tag, f), {7'd0, bits[9]}, 8'h01);
    end
    repeat (BP - BP / 2 - 1) @(posedge clk);
    #1;
    check({tag, " busy_last"}, {6'd0, rdy(sel), bsy(sel)}, 8'h01);
    @(posedge clk);
    #1;
    check({tag, " ready_back"}, {6'd0, rdy(sel), bsy(sel)}, 8'h02);
    check({tag, " line_idle"}, {7'd0, dout(sel)}, 8'h01);
  endtask

  vec_t ta [6];
  vec_t tb [3];
  vec_t vr;

  initial begin
    ta[0] = '{1'b1, 4'd0, 7'd60, 7'd100, 1'b0, 3, '{8'h90, 8'h3C, 8'h64}};
    ta[1] = '{1'b0, 4'd0, 7'd60, 7'd77,  1'b1, 2, '{8'h3C, 8'h00, 8'h00}};
    ta[2] = '{1'b1, 4'd3, 7'd64, 7'd127, 1'b0, 3, '{8'h93, 8'h40, 8'h7F}};
    ta[3] = '{1'b1, 4'd3, 7'd64, 7'd0,   1'b0, 2, '{8'h40, 8'h00, 8'h00}};
    ta[4] = '{1'b0, 4'd3, 7'd5,  7'd55,  1'b0, 2, '{8'h05, 8'h00, 8'h00}};
    ta[5] = '{1'b1, 4'd0, 7'd1,  7'd1,   1'b0, 3, '{8'h90, 8'h01, 8'h01}};
    tb[0] = '{1'b1, 4'd0, 7'd60, 7'd100, 1'b0, 3, '{8'h90, 8'h3C, 8'h64}};
    tb[1] = '{1'b1, 4'd0, 7'd60, 7'd100, 1'b0, 3, '{8'h90, 8'h3C, 8'h64}};
    tb[2] = '{1'b0, 4'd15, 7'd127, 7'd9, 1'b0, 3, '{8'h9F, 8'h7F, 8'h00}};
    vr    = '{1'b1, 4'd5, 7'd10, 7'd20,  1'b0, 3, '{8'h95, 8'h0A, 8'h14}};

    drive(1'b0, 1'b0, 1'b0, 4'd0, 7'd0, 7'd0);
    drive(1'b1, 1'b0, 1'b0, 4'd0, 7'd0, 7'd0);
    repeat (3) @(negedge clk);
    check("rst a", {5'd0, a_data, a_ready, a_busy}, 8'h06);
    check("rst b", {5'd0, b_data, b_ready, b_busy}, 8'h06);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(1'b0, ta[i], ta[(i + 1) % 6], $sformatf("a%0d", i));
    for (int i = 0; i < 3; i++) run_vec(1'b1, tb[i], tb[(i + 1) % 3], $sformatf("b%0d", i));

    // Reset during the note byte's second data bit (0x0A MSB-first: b6 = 0).
    @(negedge clk);
    drive(1'b0, 1'b1, vr.on, vr.ch, vr.note, vr.vel);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 7'd0, 7'd0);
    repeat (12 * BP + BP / 2) @(posedge clk);
    #1;
    check("mid note bit", {6'd0, a_data, a_busy}, 8'h01);
    #2 rst = 1'b1;
    #1;
    check("async rst", {5'd0, a_data, a_ready, a_busy}, 8'h06);
    @(negedge clk);
    rst = 1'b0;
    run_vec(1'b0, vr, vr, "after_rst");

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
